hs_tx_arbiter: RTL

Source-domain scheduler that shares one two-flop handshake synchronizer channel among `NUM_REQ` requesters. It round-robin arbitrates among pending requests, presents the winner's word on the synchronizer's source side (`sready`/`din`) and holds it until the four-phase return (`sidle` rise, then fall) completes. It then acknowledges the requester. It sits entirely in the source clock domain, in front of the synchronizer's source port.

---
 rtl/hs_tx_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/hs_tx_arbiter.sv
// Round-robin scheduler sharing one four-phase handshake synchronizer source port among NUM_REQ requesters.
// Optional REQ-phase abort timer enabled by defining HS_ARB_TIMEOUT_EN.
module hs_tx_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic                       hs_sready,
  output logic [WIDTH-1:0]           hs_din,
  input  logic                       hs_sidle,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic                       to_err
);

  localparam int unsigned GW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 4) begin : g_bad_cfg
    $error("hs_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT >= 4");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_REL
  } state_t;

  state_t             state, state_nxt;
  logic [GW-1:0]      prio, prio_nxt;
  logic [GW-1:0]      gnt_nxt, gnt_inc, pick;
  logic [WIDTH-1:0]   din_nxt;
  logic [NUM_REQ-1:0] cand, ack_nxt;
  logic               found, sready_nxt, busy_nxt, to_err_nxt;

`ifdef HS_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT);
  logic [CW-1:0] cnt, cnt_nxt;
`endif

  // The acknowledged requester still shows req_valid during the ack cycle; keep it out of the search.
  assign cand = req_valid & ~req_ack;

  assign gnt_inc = (gnt_id == GW'(NUM_REQ - 1)) ? '0 : gnt_id + GW'(1);

  always_comb begin : arb_search
    int unsigned  idx;
    logic [GW-1:0] idx_g;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    idx_g = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx   = (32'(prio) + k) % NUM_REQ;
      idx_g = GW'(idx);
      if (!found && cand[idx_g]) begin
        found = 1'b1;
        pick  = idx_g;
      end
    end
  end

  always_comb begin : fsm_next
    state_nxt  = state;
    gnt_nxt    = gnt_id;
    din_nxt    = hs_din;
    prio_nxt   = prio;
    ack_nxt    = '0;
    to_err_nxt = 1'b0;
`ifdef HS_ARB_TIMEOUT_EN
    cnt_nxt    = cnt;
`endif
    case (state)
      S_IDLE: begin
        if (found) begin
          state_nxt = S_REQ;
          gnt_nxt   = pick;
          din_nxt   = req_data[32'(pick)*WIDTH +: WIDTH];
`ifdef HS_ARB_TIMEOUT_EN
          cnt_nxt   = '0;
`endif
        end
      end
      S_REQ: begin
        if (hs_sidle) begin
          state_nxt = S_REL;
        end
`ifdef HS_ARB_TIMEOUT_EN
        else if (cnt == CW'(TIMEOUT - 1)) begin
          // Abort without ack: the requester keeps req_valid high and is retried in turn.
          state_nxt  = S_IDLE;
          to_err_nxt = 1'b1;
          prio_nxt   = gnt_inc;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
`endif
      end
      S_REL: begin
        if (!hs_sidle) begin
          state_nxt        = S_IDLE;
          ack_nxt[gnt_id]  = 1'b1;
          prio_nxt         = gnt_inc;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    sready_nxt = (state_nxt == S_REQ);
    busy_nxt   = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      prio      <= '0;
      gnt_id    <= '0;
      hs_din    <= '0;
      hs_sready <= 1'b0;
      busy      <= 1'b0;
      req_ack   <= '0;
      to_err    <= 1'b0;
    end else begin
      state     <= state_nxt;
      prio      <= prio_nxt;
      gnt_id    <= gnt_nxt;
      hs_din    <= din_nxt;
      hs_sready <= sready_nxt;
      busy      <= busy_nxt;
      req_ack   <= ack_nxt;
      to_err    <= to_err_nxt;
    end
  end

`ifdef HS_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_nxt;
  end
`endif

endmodule
